// File: rtl/wb_gpio_irq_ctrl.sv
// wb_gpio_irq_ctrl: Wishbone-slave GPIO controller with atomic set/clear of outputs and
// per-pin rising/falling edge capture (write-1-to-clear status, level IRQ).
//
// Optional input debouncer: define GPIO_DEBOUNCE_EN to compile it in.
//
// Ports:
//   WBs_CLK_i       clock
//   WBs_RST_i       synchronous active-high reset
//   WBs_ADR_i       word address of the register window
//   WBs_CYC_i       block chip select
//   WBs_STB_i       transfer strobe
//   WBs_WE_i        write enable
//   WBs_BYTE_STB_i  byte enables
//   WBs_DAT_i       write data
//   WBs_DAT_o       read data, valid with ACK
//   WBs_ACK_o       transfer acknowledge
//   GPIO_IN_i       asynchronous pad inputs
//   GPIO_OUT_o      pad output data
//   GPIO_OE_o       pad output enables
//   IRQ_o           level interrupt, OR of captured status
module wb_gpio_irq_ctrl #(
  parameter int unsigned GPIO_WIDTH    = 8,
  parameter int unsigned ADDRWIDTH     = 4,
  parameter logic [31:0] GPIO_OUT_DEF  = 32'h0,
  parameter logic [31:0] GPIO_OE_DEF   = 32'h0,
  parameter int unsigned DEB_DIV       = 1000,
  parameter logic [31:0] DEF_REG_VALUE = 32'hFABDEFAC
) (
  input  logic                  WBs_CLK_i,
  input  logic                  WBs_RST_i,
  input  logic [ADDRWIDTH-1:0]  WBs_ADR_i,
  input  logic                  WBs_CYC_i,
  input  logic                  WBs_STB_i,
  input  logic                  WBs_WE_i,
  input  logic [3:0]            WBs_BYTE_STB_i,
  input  logic [31:0]           WBs_DAT_i,
  output logic [31:0]           WBs_DAT_o,
  output logic                  WBs_ACK_o,
  input  logic [GPIO_WIDTH-1:0] GPIO_IN_i,
  output logic [GPIO_WIDTH-1:0] GPIO_OUT_o,
  output logic [GPIO_WIDTH-1:0] GPIO_OE_o,
  output logic                  IRQ_o
);

  localparam logic [ADDRWIDTH-1:0] OffIn   = ADDRWIDTH'(0);
  localparam logic [ADDRWIDTH-1:0] OffOut  = ADDRWIDTH'(1);
  localparam logic [ADDRWIDTH-1:0] OffOe   = ADDRWIDTH'(2);
  localparam logic [ADDRWIDTH-1:0] OffSet  = ADDRWIDTH'(3);
  localparam logic [ADDRWIDTH-1:0] OffClr  = ADDRWIDTH'(4);
  localparam logic [ADDRWIDTH-1:0] OffRise = ADDRWIDTH'(5);
  localparam logic [ADDRWIDTH-1:0] OffFall = ADDRWIDTH'(6);
  localparam logic [ADDRWIDTH-1:0] OffStat = ADDRWIDTH'(7);
  localparam logic [ADDRWIDTH-1:0] OffCfg  = ADDRWIDTH'(8);
  localparam logic [7:0]           WidthB  = 8'(GPIO_WIDTH);

  typedef logic [GPIO_WIDTH-1:0] pins_t;

  logic        ack_q;
  logic [31:0] dat_q;
  logic        irq_q;
  pins_t       out_q, out_d, oe_q, oe_d;
  pins_t       rise_en_q, rise_en_d, fall_en_q, fall_en_d;
  pins_t       stat_q, stat_d;
  pins_t       sync1_q, sync2_q, in_q, in_d, prev_q;

  logic        acc, wr;
  logic [31:0] bmask32;
  pins_t       wm, wbits, clr, rise, fall;
  logic [31:0] rdata;
  logic [7:0]  cfg_deb;

  // A new access is accepted only while no ACK is outstanding, so a held strobe
  // yields one ACK every other cycle.
  assign acc     = WBs_CYC_i & WBs_STB_i & ~ack_q;
  assign wr      = acc & WBs_WE_i;
  assign bmask32 = {{8{WBs_BYTE_STB_i[3]}}, {8{WBs_BYTE_STB_i[2]}},
                    {8{WBs_BYTE_STB_i[1]}}, {8{WBs_BYTE_STB_i[0]}}};
  assign wm      = bmask32[GPIO_WIDTH-1:0];
  assign wbits   = WBs_DAT_i[GPIO_WIDTH-1:0] & wm;

  assign rise = in_q & ~prev_q & rise_en_q;
  assign fall = ~in_q & prev_q & fall_en_q;

  always_comb begin
    out_d     = out_q;
    oe_d      = oe_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    clr       = '0;
    if (wr) begin
      case (WBs_ADR_i)
        OffOut:  out_d     = (out_q & ~wm) | wbits;
        OffOe:   oe_d      = (oe_q & ~wm) | wbits;
        OffSet:  out_d     = out_q | wbits;
        OffClr:  out_d     = out_q & ~wbits;
        OffRise: rise_en_d = (rise_en_q & ~wm) | wbits;
        OffFall: fall_en_d = (fall_en_q & ~wm) | wbits;
        OffStat: clr       = wbits;
        default: ;
      endcase
    end
    // Hardware set is applied after the W1C clear so a same-cycle edge wins.
    stat_d = (stat_q & ~clr) | rise | fall;
  end

  always_comb begin
    rdata = DEF_REG_VALUE;
    case (WBs_ADR_i)
      OffIn:   rdata = 32'(in_q);
      OffOut:  rdata = 32'(out_q);
      OffOe:   rdata = 32'(oe_q);
      OffSet:  rdata = 32'h0;
      OffClr:  rdata = 32'h0;
      OffRise: rdata = 32'(rise_en_q);
      OffFall: rdata = 32'(fall_en_q);
      OffStat: rdata = 32'(stat_q);
      OffCfg:  rdata = {16'h0, cfg_deb, WidthB};
      default: rdata = DEF_REG_VALUE;
    endcase
  end

  always_ff @(posedge WBs_CLK_i) begin
    if (WBs_RST_i) begin
      ack_q     <= 1'b0;
      dat_q     <= '0;
      irq_q     <= 1'b0;
      out_q     <= GPIO_OUT_DEF[GPIO_WIDTH-1:0];
      oe_q      <= GPIO_OE_DEF[GPIO_WIDTH-1:0];
      rise_en_q <= '0;
      fall_en_q <= '0;
      stat_q    <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      in_q      <= '0;
      prev_q    <= '0;
    end else begin
      ack_q     <= acc;
      dat_q     <= (acc & ~WBs_WE_i) ? rdata : 32'h0;
      irq_q     <= |stat_q;
      out_q     <= out_d;
      oe_q      <= oe_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      stat_q    <= stat_d;
      sync1_q   <= GPIO_IN_i;
      sync2_q   <= sync1_q;
      in_q      <= in_d;
      prev_q    <= in_q;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int unsigned CntW = (DEB_DIV > 2) ? $clog2(DEB_DIV) : 1;

  logic [CntW-1:0] cnt_q;
  logic            tick;
  // hist1_q: sample from the previous tick, hist2_q: two ticks ago.
  pins_t           hist1_q, hist2_q, all1, all0;

  assign tick    = (cnt_q == CntW'(DEB_DIV - 1));
  assign all1    = sync2_q & hist1_q & hist2_q;
  assign all0    = ~(sync2_q | hist1_q | hist2_q);
  assign in_d    = tick ? ((in_q & ~all0) | all1) : in_q;
  assign cfg_deb = 8'hDB;

  always_ff @(posedge WBs_CLK_i) begin
    if (WBs_RST_i) begin
      cnt_q   <= '0;
      hist1_q <= '0;
      hist2_q <= '0;
    end else begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
      if (tick) begin
        hist1_q <= sync2_q;
        hist2_q <= hist1_q;
      end
    end
  end
`else
  assign in_d    = sync2_q;
  assign cfg_deb = 8'h00;
`endif

  logic unused_ok;
  assign unused_ok = ^{WBs_DAT_i, bmask32, 32'(DEB_DIV)};

  assign WBs_ACK_o  = ack_q;
  assign WBs_DAT_o  = dat_q;
  assign IRQ_o      = irq_q;
  assign GPIO_OUT_o = out_q;
  assign GPIO_OE_o  = oe_q;

endmodule

// File: doc/wb_gpio_irq_ctrl.md
# wb_gpio_irq_ctrl

Parametrised Wishbone-slave GPIO controller that succeeds the fixed 8-bit GPIO register set in the FPGA register block. It supports 1–32 pins, atomic set/clear of outputs, and per-pin rising/falling-edge interrupt capture with a write-1-to-clear status. It also offers an optional input debouncer. It sits behind the FPGA aperture chip-select and drives the bipad A/EN pins, reading their Q pins.

## Interface
- GPIO_WIDTH, 8, number of pins (1–32)
- ADDRWIDTH, 4, word-address width of the register window
- GPIO_OUT_DEF, 0, reset value of OUT register (GPIO_WIDTH bits)
- GPIO_OE_DEF, 0, reset value of OE register
- DEB_DIV, 1000, debounce sample-tick period in clocks (only with GPIO_DEBOUNCE_EN, ≥2)
- DEF_REG_VALUE, 32'hFAB_DEF_AC, read value of undefined offsets

Ports:
- WBs_CLK_i  in  1  single clock
- WBs_RST_i  in  1  synchronous active-high reset
- WBs_ADR_i  in  ADDRWIDTH  word address
- WBs_CYC_i  in  1  block chip select
- WBs_STB_i  in  1  transfer strobe
- WBs_WE_i  in  1  write enable
- WBs_BYTE_STB_i  in  4  byte enables
- WBs_DAT_i  in  32  write data
- WBs_DAT_o  out  32  read data, valid with ACK
- WBs_ACK_o  out  1  transfer acknowledge
- GPIO_IN_i  in  GPIO_WIDTH  asynchronous pad inputs
- GPIO_OUT_o  out  GPIO_WIDTH  pad output data
- GPIO_OE_o  out  GPIO_WIDTH  pad output enables
- IRQ_o  out  1  level interrupt, OR of pending enabled status

## Operation
Registers use word offsets. Bits at or above GPIO_WIDTH read as 0 and ignore writes.
- 0x0 IN (RO): conditioned input value.
- 0x1 OUT (RW, byte-strobed).
- 0x2 OE (RW, byte-strobed).
- 0x3 OUT_SET (WO): OUT |= data; reads as 0.
- 0x4 OUT_CLR (WO): OUT &= ~data; reads as 0.
- 0x5 RISE_EN (RW): per-pin rising-edge capture enable.
- 0x6 FALL_EN (RW): per-pin falling-edge capture enable.
- 0x7 STAT (RW1C): captured edges; writing 1 clears that bit.
- 0x8 CFG (RO): {16'h0, 8'hDB when debounce is compiled in else 8'h00, GPIO_WIDTH[7:0]}.
- Any other offset: reads DEF_REG_VALUE; writes ignored, still ACKed.

Byte strobes apply to every writable register, including SET/CLR/STAT. A byte with strobe 0 has no effect.

Input path:
- Two-flop synchroniser, giving sync.
- Debouncer (optional).
- IN register.
- prev register holding IN delayed one cycle.

Edge capture:
- rise = IN & ~prev & RISE_EN; fall = ~IN & prev & FALL_EN.
- STAT |= rise | fall.
- If a hardware set and a W1C clear hit the same bit in the same cycle, the set wins and the bit stays 1.
- Disabling RISE_EN/FALL_EN does not clear existing STAT bits.

IRQ_o = |STAT, registered.

Reset values:
- OUT=GPIO_OUT_DEF, OE=GPIO_OE_DEF.
- RISE_EN=FALL_EN=STAT=0.
- IN/prev/sync = 0. No edge is captured on the first cycles after reset, because both enables are 0.
- WBs_ACK_o=0, WBs_DAT_o=0, IRQ_o=0.
- Reset mid-transfer drops ACK on the next edge; the master retries.

## Timing
- ACK: registered, WBs_ACK_o <= CYC & STB & ~WBs_ACK_o. The first ACK comes one clock after CYC&STB. A held strobe gives ACK every other cycle, exactly one per transfer.
- Write takes effect on the same edge that raises ACK. GPIO_OUT_o/GPIO_OE_o reflect the new value from that edge, since they are driven directly from the registers.
- Read: WBs_DAT_o is registered on the same edge as ACK, with no extra wait state.
- Pin-to-IN without debounce: a pad change sampled at edge k appears in IN at edge k+2. STAT sets at k+3 and IRQ_o rises at k+4.
- The STAT clear write lands on the ACK edge; IRQ_o falls one clock later if no other bit is pending.

## Configuration
GPIO_DEBOUNCE_EN:
- Defined:
  - A shared prescaler produces a one-cycle tick every DEB_DIV clocks.
  - On each tick, each pin shifts sync into a 3-bit history.
  - IN updates on that tick only when all 3 samples agree; otherwise IN holds.
  - Glitches shorter than 2 tick periods never reach IN or STAT.
  - CFG[15:8]=8'hDB.
- Undefined:
  - No prescaler or history logic.
  - IN = sync, delayed by one register.
  - CFG[15:8]=0.

## Test plan
- Reset then read all offsets, GPIO_WIDTH=8: IN=0, OUT=GPIO_OUT_DEF, OE=GPIO_OE_DEF, STAT=0, CFG=0x00000008; offset 0xF returns 0xFABDEFAC; IRQ_o=0.
- Write OUT=0xA5, then OUT_SET=0x0F, then OUT_CLR=0x81: reads are 0xA5 → 0xAF → 0x2E. GPIO_OUT_o matches on each ACK edge. A write with BYTE_STB=4'b0000 leaves OUT unchanged.
- RISE_EN=0x01, FALL_EN=0x02; drive pin0 0→1 and pin1 1→0: STAT=0x03 and IRQ_o=1, 4 clocks after the sampled change. Write STAT=0x01: STAT=0x02 and IRQ_o stays 1. Write 0x02: IRQ_o falls one clock later.
- Time a pin0 rising edge so STAT bit0 sets in the same cycle as a W1C of bit0: STAT bit0 remains 1.
- Back-to-back transfers with STB held for 6 cycles: exactly 3 ACK pulses, each one cycle wide.
- With GPIO_DEBOUNCE_EN and DEB_DIV=4:
  - A 5-clock pulse on pin2 leaves IN and STAT unchanged.
  - A level held for 12 clocks updates IN bit2 and sets STAT bit2 when RISE_EN bit2 = 1.
